// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: frame FIFO plus I2S / left-justified / TDM serialiser.
// The bit clock is divided down from MasterCLK. Underruns are flagged
// (sticky), frames can be muted, and the FIFO fill level is reported.
// Handshake: FrameData is accepted on a rising MasterCLK edge where
// FrameValid && FrameReady. FrameReady does not depend on FrameValid.
module i2s_tdm_tx #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_WIDTH   = 32,
   parameter int CHANNELS     = 2,
   parameter int CLK_DIV      = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                             MasterCLK,
   input  logic                             Reset,
   input  logic                             Enable,
   input  logic                             Mode,
   input  logic                             Mute,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] FrameData,
   input  logic                             FrameValid,
   output logic                             FrameReady,
   output logic [$clog2(FIFO_DEPTH):0]      FifoLevel,
   output logic                             Underrun,
   input  logic                             UnderrunClear,
   output logic                             DAC_I2S_CLK,
   output logic                             DAC_I2S_WS,
   output logic                             DAC_I2S_DATA
);
   localparam int FW = CHANNELS * SAMPLE_WIDTH;
   localparam int F  = CHANNELS * SLOT_WIDTH;
   localparam int BW = $clog2(F);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] div_q, div_d;
   logic          clk_q, clk_d;
   logic          ws_q, ws_d;
   logic [BW-1:0] b_q, b_d;
   logic [F-1:0]  sr_q, sr_d;
   logic          mode_q, mode_d;
   logic          under_q, under_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;

   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [FW-1:0] rd_data;
   logic [F-1:0]  padded;
   logic [BW-1:0] b_ws;
   logic          tick, fall, load, empty, full, push, pop;

   assign rd_data      = mem[rd_q];
   assign empty        = (lvl_q == '0);
   assign full         = (lvl_q == LW'(FIFO_DEPTH));
   assign FrameReady   = !Reset && !full;
   assign push         = FrameValid && FrameReady;
   assign tick         = Enable && (div_q == DW'(CLK_DIV - 1));
   assign fall         = tick && clk_q;
   assign load         = fall && (b_q == BW'(F - 1));
   assign pop          = load && !empty;
   assign FifoLevel    = lvl_q;
   assign Underrun     = under_q;
   assign DAC_I2S_CLK  = clk_q;
   assign DAC_I2S_WS   = ws_q;
   assign DAC_I2S_DATA = sr_q[F-1];

   // Spread the FIFO head frame into slots: ch0 first, samples MSB-aligned, zero padded.
   always_comb begin
      padded = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         padded[(CHANNELS-c)*SLOT_WIDTH-1 -: SAMPLE_WIDTH] =
            rd_data[(CHANNELS-c)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
      end
   end

   // Next-state: FIFO pointers/level, underrun flag, divider, bit counter, shifter, WS.
   always_comb begin
      div_d   = div_q;
      clk_d   = clk_q;
      ws_d    = ws_q;
      b_d     = b_q;
      sr_d    = sr_q;
      mode_d  = mode_q;
      under_d = under_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      lvl_d   = lvl_q + LW'(push) - LW'(pop);
      b_ws    = '0;

      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);

      // A new underrun beats a simultaneous clear.
      if (UnderrunClear) under_d = 1'b0;
      if (load && empty) under_d = 1'b1;

      if (!Enable) begin
         div_d = '0;
         clk_d = 1'b0;
         ws_d  = 1'b0;
         b_d   = BW'(F - 1);
         sr_d  = '0;
      end else begin
         div_d = tick ? '0 : div_q + DW'(1);
         if (tick) clk_d = !clk_q;
         if (fall) begin
            if (load) begin
               b_d    = '0;
               mode_d = Mode;
               sr_d   = (empty || Mute) ? '0 : padded;
            end else begin
               b_d  = b_q + BW'(1);
               sr_d = {sr_q[F-2:0], 1'b0};
            end
            // I2S mode looks one bit ahead so WS leads the MSB by one bit clock.
            if (mode_d) b_ws = b_d;
            else        b_ws = (b_d == BW'(F - 1)) ? '0 : b_d + BW'(1);
            if (CHANNELS == 2) ws_d = (b_ws >= BW'(SLOT_WIDTH));
            else               ws_d = (b_ws == '0);
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge MasterCLK) begin
      if (Reset) begin
         div_q   <= '0;
         clk_q   <= 1'b0;
         ws_q    <= 1'b0;
         b_q     <= BW'(F - 1);
         sr_q    <= '0;
         mode_q  <= 1'b0;
         under_q <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         lvl_q   <= '0;
      end else begin
         div_q   <= div_d;
         clk_q   <= clk_d;
         ws_q    <= ws_d;
         b_q     <= b_d;
         sr_q    <= sr_d;
         mode_q  <= mode_d;
         under_q <= under_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         lvl_q   <= lvl_d;
      end
   end

   // Frame storage; no reset needed since the level gates every read.
   always_ff @(posedge MasterCLK) begin
      if (push) mem[wr_q] <= FrameData;
   end

endmodule
